// File: rtl/mult_eval_ctrl.sv
// Exhaustive sweep controller for candidate WIDTHxWIDTH multipliers: applies every
// operand pair, counts mismatches, and reports pass. Optional macro: MULT_EVAL_FIRSTFAIL_EN.
module mult_eval_ctrl #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 2*WIDTH+1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   cand_a,
  output logic [WIDTH-1:0]   cand_b,
  input  logic [2*WIDTH-1:0] cand_p,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic               pass,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2*WIDTH-1:0] OP_MAX = '1;

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] op;
  logic [2*WIDTH-1:0] exact;
  logic               mismatch;
  logic               accept;
  logic               compare;

  // Operands come straight from the registered index, so they are registered outputs.
  assign cand_a   = op[2*WIDTH-1:WIDTH];
  assign cand_b   = op[WIDTH-1:0];
  assign exact    = {{WIDTH{1'b0}}, cand_a} * {{WIDTH{1'b0}}, cand_b};
  assign mismatch = (cand_p != exact);
  assign accept   = (state == IDLE) && start && !abort;
  assign compare  = (state == RUN) && !abort;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN: begin
        if (abort)              state_nx = IDLE;
        else if (op == OP_MAX)  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      op        <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (compare) begin
      if (mismatch)     err_count <= err_count + CNT_W'(1);
      if (op != OP_MAX) op <= op + (2*WIDTH)'(1);
    end else if (state == DONE) begin
      pass <= (err_count == '0);
    end
  end

`ifdef MULT_EVAL_FIRSTFAIL_EN
  logic ff_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_seen      <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (accept) begin
      ff_seen      <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else if (compare && mismatch && !ff_seen) begin
      ff_seen      <= 1'b1;
      first_fail_a <= cand_a;
      first_fail_b <= cand_b;
    end
  end
`else
  assign first_fail_a = '0;
  assign first_fail_b = '0;
`endif

endmodule

// File: tb/tb_mult_eval_ctrl.sv
// Scoreboard bench for mult_eval_ctrl (WIDTH=2): directed sweeps with behavioural
// candidate multipliers; a monitor pops expected sweep results on each done pulse.
module tb_mult_eval_ctrl;

  localparam int W  = 2;
  localparam int CW = 2*W+1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cand_a, cand_b;
  logic [2*W-1:0] cand_p;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [W-1:0]  first_fail_a, first_fail_b;

  int mode = 0;   // 0 exact, 1 stuck at zero, 2 exact except 2*3 -> 0
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int err;
    int pss;
    int ffa;
    int ffb;
    int done_cyc;
  } exp_t;

  exp_t sb[$];

  mult_eval_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cand_a(cand_a), .cand_b(cand_b), .cand_p(cand_p),
    .busy(busy), .done(done), .err_count(err_count), .pass(pass),
    .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cand_p = '0;
    case (mode)
      0: cand_p = {2'b00, cand_a} * {2'b00, cand_b};
      1: cand_p = '0;
      default: cand_p = (cand_a == 2'd2 && cand_b == 2'd3) ? 4'd0 : {2'b00, cand_a} * {2'b00, cand_b};
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef MULT_EVAL_FIRSTFAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  function automatic exp_t mk(input int e, input int p, input int a, input int b, input int dc);
    exp_t x;
    x.err = e; x.pss = p;
    x.ffa = FF_EN ? a : 0;
    x.ffb = FF_EN ? b : 0;
    x.done_cyc = dc;
    return x;
  endfunction

  // Monitor: pops on done, checks the held results one cycle later.
  initial begin
    exp_t cur;
    bit   pend = 1'b0;
    int   busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        busy_cnt = 0;
      end else begin
        if (pend) begin
          check("pass", 32'(pass), 32'(cur.pss));
          check("first_fail_a", 32'(first_fail_a), 32'(cur.ffa));
          check("first_fail_b", 32'(first_fail_b), 32'(cur.ffb));
          pend = 1'b0;
        end
        if (busy) busy_cnt++;
        else if (!done) busy_cnt = 0;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(1), 32'(0));
          end else begin
            cur = sb.pop_front();
            check("err_count", 32'(err_count), 32'(cur.err));
            check("done_cycle", 32'(cyc), 32'(cur.done_cyc));
            check("busy_cycles", 32'(busy_cnt), 32'(16));
            check("busy_at_done", 32'(busy), 32'(0));
            pend = 1'b1;
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic sweep(input int m, input int e, input int p, input int a, input int b);
    @(negedge clk);
    mode = m;
    sb.push_back(mk(e, p, a, b, cyc + 17));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  // Abort sampled at the edge ending RUN cycle k; vectors 0..k-2 are counted.
  task automatic abort_at(input int k, input int e, input int a, input int b);
    @(negedge clk);
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_err", 32'(err_count), 32'(e));
    check("abort_pass", 32'(pass), 32'(0));
    check("abort_ffa", 32'(first_fail_a), 32'(FF_EN ? a : 0));
    check("abort_ffb", 32'(first_fail_b), 32'(FF_EN ? b : 0));
    repeat (3) @(negedge clk);
    check("abort_hold_err", 32'(err_count), 32'(e));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err_count), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_ab", 32'({cand_a, cand_b}), 32'(0));
    check("rst_ff", 32'({first_fail_a, first_fail_b}), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(0, 0, 1, 0, 0);
    sweep(1, 9, 0, 1, 1);
    sweep(2, 1, 0, 2, 3);
    check("hold_err", 32'(err_count), 32'(1));
    check("hold_pass", 32'(pass), 32'(0));

    // Stuck-zero mismatches start at vector 5 (1,1): 8th cycle leaves 5,6; 9th adds 7.
    abort_at(8, 2, 1, 1);
    abort_at(9, 3, 1, 1);

    // start with abort in IDLE is refused
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 32'(busy), 32'(0));
    check("idle_abort_err", 32'(err_count), 32'(3));

    // start held: accepts at edges 1 and 19; a third would need the 37th edge.
    @(negedge clk);
    mode = 0;
    n = cyc;
    sb.push_back(mk(0, 1, 0, 0, n + 17));
    sb.push_back(mk(0, 1, 0, 0, n + 35));
    start = 1'b1;
    repeat (36) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_busy_after", 32'(busy), 32'(0));

    // Asynchronous reset mid-run
    @(negedge clk);
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_err", 32'(err_count), 32'(2));
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_err", 32'(err_count), 32'(0));
    check("arst_pass", 32'(pass), 32'(0));
    check("arst_ab", 32'({cand_a, cand_b}), 32'(0));
    check("arst_ff", 32'({first_fail_a, first_fail_b}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(0, 0, 1, 0, 0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
